// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Purpose  : Instruction-fetch stage: fetch PC, imem address, IF/ID register.
// Revision : 1.0
// ============================================================================
module if_stage #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_f,
    input  logic            stall_d,
    input  logic            flush_d,
    input  logic            pc_src_e,
    input  logic [XLEN-1:0] pc_target_e,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus4_d,
    output logic            valid_d,
    output logic            misalign_err,
    output logic [31:0]     fetch_count
);

    localparam logic [XLEN-1:0] c_pc_step = XLEN'(4);

    logic [XLEN-1:0] r_pc_f;
    logic [31:0]     r_instr_d;
    logic [XLEN-1:0] r_pc_d;
    logic [XLEN-1:0] r_pc_plus4_d;
    logic            r_valid_d;
    logic            r_misalign_err;
    logic [31:0]     r_fetch_count;

    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_redirect_pc;
    logic [XLEN-1:0] w_pc_next;
    logic            w_load_d;
    logic            w_target_misaligned;

    assign w_pc_plus4          = r_pc_f + c_pc_step;
    assign w_redirect_pc       = {pc_target_e[XLEN-1:2], 2'b00};
    assign w_target_misaligned = pc_src_e && (pc_target_e[1:0] != 2'b00);
    assign w_load_d            = !flush_d && !stall_d;

    // A redirect wins over a fetch stall so a resolved branch is never lost.
    always_comb begin
        w_pc_next = r_pc_f;
        if (pc_src_e) begin
            w_pc_next = w_redirect_pc;
        end else if (!stall_f) begin
            w_pc_next = w_pc_plus4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc_f <= RESET_PC;
        end else begin
            r_pc_f <= w_pc_next;
        end
    end

    // Flush beats stall: a squashed slot must not hold a wrong-path instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= '0;
            r_pc_plus4_d <= '0;
            r_valid_d    <= 1'b0;
        end else if (flush_d) begin
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= '0;
            r_pc_plus4_d <= '0;
            r_valid_d    <= 1'b0;
        end else if (!stall_d) begin
            r_instr_d    <= imem_rdata;
            r_pc_d       <= r_pc_f;
            r_pc_plus4_d <= w_pc_plus4;
            r_valid_d    <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_misalign_err <= 1'b0;
            r_fetch_count  <= '0;
        end else begin
            if (w_target_misaligned) begin
                r_misalign_err <= 1'b1;
            end
            if (w_load_d) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    assign imem_addr    = r_pc_f;
    assign instr_d      = r_instr_d;
    assign pc_d         = r_pc_d;
    assign pc_plus4_d   = r_pc_plus4_d;
    assign valid_d      = r_valid_d;
    assign misalign_err = r_misalign_err;
    assign fetch_count  = r_fetch_count;

endmodule
`default_nettype wire
